toggle_event_receiver: RTL

//  Receive end of the two-phase toggle link. A remote T flip-flop encodes each event as one level flip on tog_in.

---
 rtl/toggle_event_receiver.sv | 112 +++++++++++
 1 files changed

// File: rtl/toggle_event_receiver.sv
// Receive end of a two-phase toggle link: synchronizes tog_in, decodes each flip into a valid/ready event,
// returns a toggle acknowledge per accepted event and flags overruns. Optional statistics under TOGGLE_RX_STATS_EN.
module toggle_event_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tog_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             tog_ack,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] evt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ref_q;
  logic                   edge_s;
  state_e                 state_q;
  logic                   ack_q;
  logic                   ovf_q;
  logic                   accept_s;
  logic                   overrun_s;

  // Synchronizer chain plus edge-reference flop; sync_q[0] takes the raw line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      ref_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      ref_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_s    = sync_q[SYNC_STAGES-1] ^ ref_q;
  assign accept_s  = (state_q == ST_PEND) && evt_ready;
  assign overrun_s = (state_q == ST_PEND) && !evt_ready && edge_s;

  // Event FSM with registered acknowledge and sticky overrun flag; a new edge during an accept re-arms PEND.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (edge_s) state_q <= ST_PEND;
          else        state_q <= ST_IDLE;
        end
        ST_PEND: begin
          if (evt_ready && !edge_s) state_q <= ST_IDLE;
          else                      state_q <= ST_PEND;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (accept_s) ack_q <= ~ack_q;
      else          ack_q <= ack_q;
      if (overrun_s)    ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      else              ovf_q <= ovf_q;
    end
  end

  assign evt_valid = (state_q == ST_PEND);
  assign tog_ack   = ack_q;
  assign ovf       = ovf_q;

`ifdef TOGGLE_RX_STATS_EN
  logic [CNT_W-1:0] evt_cnt_q;
  logic [CNT_W-1:0] evt_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;

  // evt_cnt wraps; drop_cnt saturates at all-ones.
  always_comb begin
    evt_cnt_d  = evt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (edge_s) evt_cnt_d = evt_cnt_q + CNT_W'(1);
    else        evt_cnt_d = evt_cnt_q;
    if (overrun_s && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    else                                            drop_cnt_d = drop_cnt_q;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      evt_cnt_q  <= evt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign evt_cnt  = evt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign evt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule
